inst_fetch: RTL

Instruction-fetch stage, directly upstream of the main control decoder. Holds the PC and issues one word fetch at a time to instruction memory. Accepts branch/jump redirects from later stages and presents a registered instruction to decode, with its 6-bit opcode field driving the control decoder's Op input. Multi-cycle, single-outstanding-request design with a stall/flush handshake.

---
 rtl/inst_fetch.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC register, single-outstanding fetch, registered output to decode.
// Optional IF_PERF_CNT_EN adds consumed-instruction and squash counters.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [5:0]  if_op,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [15:0] perf_squash_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        VALID = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        squash_q, squash_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        fetch_inc, squash_inc;
    logic [31:0] redir_pc;

    assign redir_pc = {redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            squash_q   <= 1'b0;
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            squash_q   <= squash_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        squash_d   = squash_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        fetch_inc  = 1'b0;
        squash_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect_valid) pc_d = redir_pc;
                state_d = FETCH;
            end
            FETCH: begin
                // The request at the old pc is already on the bus; its response must be dropped.
                if (redirect_valid) begin
                    pc_d     = redir_pc;
                    squash_d = 1'b1;
                end
                state_d = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (squash_q || redirect_valid) begin
                        if (redirect_valid) pc_d = redir_pc;
                        squash_d   = 1'b0;
                        squash_inc = 1'b1;
                        state_d    = FETCH;
                    end else begin
                        if_instr_d = imem_rdata;
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                        pc_d       = pc_q + 32'd4;
                        state_d    = VALID;
                    end
                end else if (redirect_valid) begin
                    pc_d     = redir_pc;
                    squash_d = 1'b1;
                end
            end
            VALID: begin
                if (redirect_valid) begin
                    pc_d       = redir_pc;
                    if_valid_d = 1'b0;
                    squash_inc = 1'b1;
                    state_d    = FETCH;
                end else if (!stall) begin
                    if_valid_d = 1'b0;
                    fetch_inc  = 1'b1;
                    state_d    = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_op       = if_instr_q[31:26];
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_q + 32'd4;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_q;
    logic [15:0] perf_squash_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q  <= '0;
            perf_squash_q <= '0;
        end else begin
            if (fetch_inc)  perf_fetch_q  <= perf_fetch_q + 32'd1;
            if (squash_inc) perf_squash_q <= perf_squash_q + 16'd1;
        end
    end

    assign perf_fetch_cnt  = perf_fetch_q;
    assign perf_squash_cnt = perf_squash_q;
`else
    logic unused_perf;
    assign unused_perf = fetch_inc ^ squash_inc;
`endif

endmodule
